cpu_control_unit: RTL and testbench
===================================

Name: cpu_control_unit

Overview:
- Multi-cycle control FSM for the 4-bit CPU.
- Sits between instruction memory (8-bit instruction, combinational read) and the datapath: program counter, 4x4 register file, 4-bit ALU and 16x4 data memory.
- Latches each instruction, decodes it, and sequences register reads, ALU operation, memory access, writeback and PC advance.
- Register file and data memory use rw=0 write, rw=1 read, with registered read data and one-cycle latency.

Parameters:
- IW, 8, instruction width
- RW, 2, register-select width (4 registers)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- instr  in  8  instruction from instruction memory at current PC
- pc_en  out  1  one-cycle pulse; PC increments on this edge
- rf_rw  out  1  register file 0=write, 1=read
- rf_read_reg1  out  2  rd field (first operand / store data)
- rf_read_reg2  out  2  rs field (second operand / memory address)
- rf_write_reg  out  2  rd field
- wb_sel  out  1  writeback source: 0=ALU result, 1=memory read_data
- alu_op  out  2  ALU operation: 0=AND, 1=OR, 2=ADD/SUB, 3=SLT
- alu_binv  out  1  ALU B-invert
- alu_cin  out  1  ALU carry-in
- mem_rw  out  1  data memory 0=write, 1=read
- halted  out  1  high while in HALT
- state_dbg  out  3  current FSM state encoding

Behaviour:
- Instruction format:
  - [7:5] opcode; [4] reserved, ignored; [3:2] rd; [1:0] rs.
  - Opcodes: 000 AND, 001 OR, 010 ADD, 011 SUB, 100 SLT (all rd <= rd op rs); 101 LW (rd <= mem[R[rs]]); 110 SW (mem[R[rs]] <= R[rd]); 111 HALT.
- ALU control decode, from IR:
  - AND: op0, binv0, cin0.
  - OR: op1, binv0, cin0.
  - ADD: op2, binv0, cin0.
  - SUB: op2, binv1, cin1.
  - SLT: op3, binv1, cin1.
  - LW/SW/HALT: op0, binv0, cin0.
- Register selects are decoded combinationally from IR in every state.
- IR: 8-bit register, loaded from instr only at the end of FETCH.
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5. Outputs are Moore-style, decoded from state and IR.
- FETCH: IR <= instr; go to DECODE.
- DECODE:
  - rf_rw=1; operands are registered in the register file at the end of this cycle.
  - HALT opcode -> HALT state; otherwise -> EXEC.
- EXEC:
  - rf_rw=1; ALU operands valid; ALU controls driven.
  - ALU ops -> WB; LW/SW -> MEM.
- MEM:
  - SW: mem_rw=0 and pc_en=1, then -> FETCH.
  - LW: mem_rw=1, then -> WB (read_data valid in WB).
- WB:
  - rf_rw=0, pc_en=1, then -> FETCH.
  - wb_sel=1 for LW, 0 otherwise.
  - ALU controls remain driven so the result is stable; register-file outputs hold while rw=0.
- HALT:
  - halted=1, pc_en=0, rf_rw=1, mem_rw=1.
  - Remains in HALT until rst.
- Latency:
  - ALU op and SW: 4 cycles.
  - LW: 5 cycles.
  - HALT: 2 cycles to enter.
- pc_en is high in exactly one cycle per completed instruction.
- Default outside the listed states: rf_rw=1, mem_rw=1, wb_sel=0, pc_en=0. No write strobe is ever active outside WB or SW-MEM.
- Reset:
  - rst sampled high at any state, including mid-instruction, puts the FSM in FETCH and clears IR to 0 at that edge.
  - Reset values: pc_en=0, rf_rw=1, mem_rw=1, wb_sel=0, alu_op=0, alu_binv=0, alu_cin=0, halted=0, all register selects 0, state_dbg=0.
  - An aborted instruction performs no write.
  - rst has priority over every transition.
- Reserved bit 4 never affects behaviour.
- PC wrap 15->0 is handled by the PC; this block is unaffected.

Optional Feature:
- Macro: CPU_CTRL_SINGLE_STEP_EN.
- When defined:
  - Adds input port step (1 bit).
  - The FSM stays in FETCH, without loading IR, until step=1 is sampled. It then loads IR and proceeds as normal.
  - step has no effect in other states.
- When undefined: no step port; FETCH always advances after one cycle.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - opcode localparams (OP_AND..OP_HALT);
  - state encodings (S_FETCH..S_HALT);
  - ALU op constants (ALU_AND, ALU_OR, ALU_ADD, ALU_SLT);
  - field bit positions.
- Sub-module ctrl_decode: combinational IR -> alu_op, alu_binv, alu_cin, is_alu, is_lw, is_sw, is_halt.
- The FSM and IR live in cpu_control_unit.

Test Plan:
- rst=1 for 3 cycles, then release with instr=8'h48 (ADD r2,r0) -> all outputs at reset values during rst; states 0,1,2,4; alu_op=2, binv=0; rf_rw=0 with rf_write_reg=2 in cycle 4; pc_en pulse in cycle 4 only.
- instr=8'h65 (SUB r1,r1) -> EXEC and WB show alu_op=2, alu_binv=1, alu_cin=1; wb_sel=0.
- instr=8'hA6 (LW r1,[r2]) -> states 0,1,2,3,4; mem_rw=1 in MEM; WB has wb_sel=1, rf_rw=0, rf_write_reg=1; 5-cycle spacing between pc_en pulses.
- instr=8'hCB (SW r2,[r3]) -> MEM has mem_rw=0 and pc_en=1; rf_rw never 0; next cycle is FETCH.
- instr=8'hFF -> HALT after 2 cycles; halted=1; pc_en stays 0 for 20 cycles; rst=1 then returns to FETCH with halted=0.
- rst asserted during LW's MEM state -> FETCH next cycle, rf_rw never 0; with CPU_CTRL_SINGLE_STEP_EN, step held 0 keeps state 0 and IR unchanged.

Source files
------------

// File: rtl/cpu_control_unit_pkg.sv
// ============================================================================
//  Module   : cpu_ctrl_pkg
//  Purpose  : Shared opcodes, FSM state encodings, ALU controls and
//             instruction field positions for the 4-bit CPU control unit.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_ctrl_pkg;

    // Instruction field positions: [7:5] opcode, [4] reserved, [3:2] rd, [1:0] rs
    localparam int OPC_MSB = 7;
    localparam int OPC_LSB = 5;
    localparam int RSV_BIT = 4;
    localparam int RD_MSB  = 3;
    localparam int RD_LSB  = 2;
    localparam int RS_MSB  = 1;
    localparam int RS_LSB  = 0;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_SLT  = 3'b100;
    localparam logic [2:0] OP_LW   = 3'b101;
    localparam logic [2:0] OP_SW   = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    typedef enum logic [2:0] {
        ST_FETCH  = S_FETCH,
        ST_DECODE = S_DECODE,
        ST_EXEC   = S_EXEC,
        ST_MEM    = S_MEM,
        ST_WB     = S_WB,
        ST_HALT   = S_HALT
    } state_t;

    localparam logic [1:0] ALU_AND = 2'd0;
    localparam logic [1:0] ALU_OR  = 2'd1;
    localparam logic [1:0] ALU_ADD = 2'd2;
    localparam logic [1:0] ALU_SLT = 2'd3;

endpackage

`default_nettype wire

// File: rtl/cpu_control_unit_decode.sv
// ============================================================================
//  Module   : ctrl_decode
//  Purpose  : Combinational instruction decode: ALU controls and class flags.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ctrl_decode
    import cpu_ctrl_pkg::*;
#(
    parameter int IW = 8
) (
    input  logic [IW-1:0] i_ir,
    output logic [1:0]    o_alu_op,
    output logic          o_alu_binv,
    output logic          o_alu_cin,
    output logic          o_is_alu,
    output logic          o_is_lw,
    output logic          o_is_sw,
    output logic          o_is_halt
);

    logic [2:0] w_opc;
    logic       w_unused_fields;

    assign w_opc           = i_ir[OPC_MSB:OPC_LSB];
    assign w_unused_fields = ^i_ir[RSV_BIT:0];

    always_comb begin
        o_alu_op   = ALU_AND;
        o_alu_binv = 1'b0;
        o_alu_cin  = 1'b0;
        o_is_alu   = 1'b0;
        o_is_lw    = 1'b0;
        o_is_sw    = 1'b0;
        o_is_halt  = 1'b0;
        case (w_opc)
            OP_AND: begin
                o_is_alu = 1'b1;
            end
            OP_OR: begin
                o_is_alu = 1'b1;
                o_alu_op = ALU_OR;
            end
            OP_ADD: begin
                o_is_alu = 1'b1;
                o_alu_op = ALU_ADD;
            end
            // Subtract and set-less-than both use the inverted-B, carry-in-1 adder path
            OP_SUB: begin
                o_is_alu   = 1'b1;
                o_alu_op   = ALU_ADD;
                o_alu_binv = 1'b1;
                o_alu_cin  = 1'b1;
            end
            OP_SLT: begin
                o_is_alu   = 1'b1;
                o_alu_op   = ALU_SLT;
                o_alu_binv = 1'b1;
                o_alu_cin  = 1'b1;
            end
            OP_LW:   o_is_lw   = 1'b1;
            OP_SW:   o_is_sw   = 1'b1;
            OP_HALT: o_is_halt = 1'b1;
            default: o_is_halt = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/cpu_control_unit.sv
// ============================================================================
//  Module   : cpu_control_unit
//  Purpose  : Multi-cycle control FSM for the 4-bit CPU; latches, decodes and
//             sequences each instruction. Optional CPU_CTRL_SINGLE_STEP_EN
//             adds an i_step input that gates leaving FETCH.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_control_unit
    import cpu_ctrl_pkg::*;
#(
    parameter int IW = 8,
    parameter int RW = 2
) (
    input  logic          clk,
    input  logic          rst,
`ifdef CPU_CTRL_SINGLE_STEP_EN
    input  logic          i_step,
`endif
    input  logic [IW-1:0] i_instr,
    output logic          o_pc_en,
    output logic          o_rf_rw,
    output logic [RW-1:0] o_rf_read_reg1,
    output logic [RW-1:0] o_rf_read_reg2,
    output logic [RW-1:0] o_rf_write_reg,
    output logic          o_wb_sel,
    output logic [1:0]    o_alu_op,
    output logic          o_alu_binv,
    output logic          o_alu_cin,
    output logic          o_mem_rw,
    output logic          o_halted,
    output logic [2:0]    o_state_dbg
);

    state_t        r_state;
    state_t        w_next;
    logic [IW-1:0] r_ir;
    logic          w_step;
    logic          w_ir_load;

    logic [1:0]    w_dec_op;
    logic          w_dec_binv;
    logic          w_dec_cin;
    logic          w_is_alu;
    logic          w_is_lw;
    logic          w_is_sw;
    logic          w_is_halt;

`ifdef CPU_CTRL_SINGLE_STEP_EN
    assign w_step = i_step;
`else
    assign w_step = 1'b1;
`endif

    assign w_ir_load = (r_state == ST_FETCH) && w_step;

    ctrl_decode #(
        .IW (IW)
    ) u_decode (
        .i_ir       (r_ir),
        .o_alu_op   (w_dec_op),
        .o_alu_binv (w_dec_binv),
        .o_alu_cin  (w_dec_cin),
        .o_is_alu   (w_is_alu),
        .o_is_lw    (w_is_lw),
        .o_is_sw    (w_is_sw),
        .o_is_halt  (w_is_halt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_FETCH;
            r_ir    <= '0;
        end else begin
            r_state <= w_next;
            if (w_ir_load) begin
                r_ir <= i_instr;
            end
        end
    end

    assign o_rf_read_reg1 = r_ir[RD_MSB:RD_LSB];
    assign o_rf_read_reg2 = r_ir[RS_MSB:RS_LSB];
    assign o_rf_write_reg = r_ir[RD_MSB:RD_LSB];
    assign o_state_dbg    = r_state;

    always_comb begin
        w_next     = r_state;
        o_pc_en    = 1'b0;
        o_rf_rw    = 1'b1;
        o_mem_rw   = 1'b1;
        o_wb_sel   = 1'b0;
        o_alu_op   = ALU_AND;
        o_alu_binv = 1'b0;
        o_alu_cin  = 1'b0;
        o_halted   = 1'b0;
        case (r_state)
            ST_FETCH: begin
                if (w_step) begin
                    w_next = ST_DECODE;
                end
            end
            ST_DECODE: begin
                w_next = w_is_halt ? ST_HALT : ST_EXEC;
            end
            ST_EXEC: begin
                o_alu_op   = w_dec_op;
                o_alu_binv = w_dec_binv;
                o_alu_cin  = w_dec_cin;
                if (w_is_alu) begin
                    w_next = ST_WB;
                end else if (w_is_lw || w_is_sw) begin
                    w_next = ST_MEM;
                end else begin
                    w_next = ST_FETCH;
                end
            end
            ST_MEM: begin
                if (w_is_sw) begin
                    o_mem_rw = 1'b0;
                    o_pc_en  = 1'b1;
                    w_next   = ST_FETCH;
                end else if (w_is_lw) begin
                    w_next = ST_WB;
                end else begin
                    w_next = ST_FETCH;
                end
            end
            // ALU controls stay asserted so the result is stable while written back
            ST_WB: begin
                o_alu_op   = w_dec_op;
                o_alu_binv = w_dec_binv;
                o_alu_cin  = w_dec_cin;
                o_rf_rw    = 1'b0;
                o_pc_en    = 1'b1;
                o_wb_sel   = w_is_lw;
                w_next     = ST_FETCH;
            end
            ST_HALT: begin
                o_halted = 1'b1;
            end
            default: begin
                w_next = ST_FETCH;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_cpu_control_unit.sv
// ============================================================================
//  Module   : tb_cpu_control_unit
//  Purpose  : Self-checking bench for cpu_control_unit against a per-instruction
//             cycle model (directed plus random instruction streams).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cpu_control_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] instr = 8'h00;
    logic       step = 1'b1;

    logic       pc_en, rf_rw, wb_sel, alu_binv, alu_cin, mem_rw, halted;
    logic [1:0] rr1, rr2, wr, alu_op;
    logic [2:0] state_dbg;

    int         total = 0;
    int         bad = 0;
    logic [7:0] prev_ir = 8'h00;

    cpu_control_unit dut (
        .clk            (clk),
        .rst            (rst),
`ifdef CPU_CTRL_SINGLE_STEP_EN
        .i_step         (step),
`endif
        .i_instr        (instr),
        .o_pc_en        (pc_en),
        .o_rf_rw        (rf_rw),
        .o_rf_read_reg1 (rr1),
        .o_rf_read_reg2 (rr2),
        .o_rf_write_reg (wr),
        .o_wb_sel       (wb_sel),
        .o_alu_op       (alu_op),
        .o_alu_binv     (alu_binv),
        .o_alu_cin      (alu_cin),
        .o_mem_rw       (mem_rw),
        .o_halted       (halted),
        .o_state_dbg    (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // irv is the instruction whose rd/rs fields the selects must reflect
    task automatic chk_all(input string tag, input logic [2:0] st, input logic pc,
                           input logic rfrw, input logic memrw, input logic wbs,
                           input logic [1:0] aop, input logic binv, input logic cin,
                           input logic hlt, input logic [7:0] irv);
        chk({tag, ".state"},  {5'b0, state_dbg}, {5'b0, st});
        chk({tag, ".pc_en"},  {7'b0, pc_en},     {7'b0, pc});
        chk({tag, ".rf_rw"},  {7'b0, rf_rw},     {7'b0, rfrw});
        chk({tag, ".mem_rw"}, {7'b0, mem_rw},    {7'b0, memrw});
        chk({tag, ".wb_sel"}, {7'b0, wb_sel},    {7'b0, wbs});
        chk({tag, ".alu_op"}, {6'b0, alu_op},    {6'b0, aop});
        chk({tag, ".binv"},   {7'b0, alu_binv},  {7'b0, binv});
        chk({tag, ".cin"},    {7'b0, alu_cin},   {7'b0, cin});
        chk({tag, ".halted"}, {7'b0, halted},    {7'b0, hlt});
        chk({tag, ".rreg1"},  {6'b0, rr1},       {6'b0, irv[3:2]});
        chk({tag, ".rreg2"},  {6'b0, rr2},       {6'b0, irv[1:0]});
        chk({tag, ".wreg"},   {6'b0, wr},        {6'b0, irv[3:2]});
    endtask

    // Enters and leaves at a falling edge; returns in the first FETCH cycle after reset
    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) begin
            instr = 8'($urandom);
            @(negedge clk);
            chk_all("reset", 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8'h00);
        end
        rst = 1'b0;
        prev_ir = 8'h00;
    endtask

    // Cycle-level model of one non-HALT instruction: ALU ops and SW take 4 cycles,
    // LW takes 5; the final cycle carries pc_en plus the instruction's single write.
    task automatic run_instr(input logic [7:0] ins, input int abort_at);
        logic [2:0] op;
        bit         is_alu, is_lw, is_sw, last;
        int         len;
        logic [2:0] st;
        logic [1:0] aop;
        logic       binv, cin;
        op     = ins[7:5];
        is_alu = (op <= 3'd4);
        is_lw  = (op == 3'd5);
        is_sw  = (op == 3'd6);
        len    = is_lw ? 5 : 4;
        case (op)
            3'd1:    {aop, binv, cin} = {2'd1, 1'b0, 1'b0};
            3'd2:    {aop, binv, cin} = {2'd2, 1'b0, 1'b0};
            3'd3:    {aop, binv, cin} = {2'd2, 1'b1, 1'b1};
            3'd4:    {aop, binv, cin} = {2'd3, 1'b1, 1'b1};
            default: {aop, binv, cin} = {2'd0, 1'b0, 1'b0};
        endcase
        for (int k = 0; k < len; k++) begin
            last = (k == len - 1);
            if (k < 3)      st = 3'(k);
            else if (is_alu) st = 3'd4;
            else if (k == 3) st = 3'd3;
            else             st = 3'd4;
            chk_all($sformatf("i%02h.k%0d", ins, k), st, last,
                    !(last && (is_alu || is_lw)), !(last && is_sw), last && is_lw,
                    (is_alu && k >= 2) ? aop : 2'd0,
                    is_alu && k >= 2 && binv, is_alu && k >= 2 && cin,
                    1'b0, (k == 0) ? prev_ir : ins);
            if (k == abort_at) return;
            instr = (k == 0) ? ins : 8'($urandom);
            if (last) prev_ir = ins;
            @(negedge clk);
        end
    endtask

    task automatic run_halt(input logic [7:0] ins, input int n);
        chk_all("h.fetch", 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, prev_ir);
        instr = ins;
        @(negedge clk);
        chk_all("h.decode", 3'd1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, ins);
        instr = 8'($urandom);
        repeat (n) begin
            @(negedge clk);
            chk_all("h.halt", 3'd5, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, ins);
            instr = 8'($urandom);
        end
    endtask

    function automatic logic [7:0] rand_instr();
        logic [7:0] r;
        r      = 8'($urandom);
        r[7:5] = 3'($urandom_range(0, 6));
        return r;
    endfunction

    initial begin
        do_reset(3);
        run_instr(8'h48, -1);
        run_instr(8'h65, -1);
        run_instr(8'hA6, -1);
        run_instr(8'hCB, -1);
        run_instr(8'h90, -1);
        run_instr(8'h3F, -1);
        for (int i = 0; i < 40; i++) begin
            run_instr(rand_instr(), -1);
        end

        // Abort a load in MEM: reset wins and no writeback cycle appears
        run_instr(8'hB7, 3);
        do_reset(1);
        for (int i = 0; i < 10; i++) begin
            run_instr(rand_instr(), -1);
        end

`ifdef CPU_CTRL_SINGLE_STEP_EN
        step = 1'b0;
        for (int i = 0; i < 5; i++) begin
            instr = 8'($urandom);
            @(negedge clk);
            chk_all("stephold", 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, prev_ir);
        end
        step = 1'b1;
        run_instr(8'h5E, -1);
        run_instr(rand_instr(), -1);
`endif

        run_halt(8'hFF, 20);
        do_reset(2);
        run_instr(8'h4D, -1);
        run_halt(8'hE0, 5);
        do_reset(1);
        run_instr(8'hC4, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
